// File: rtl/conv_pkg.sv
// Shared constants and pixel type for the conv_* streaming stages
// (line buffer and Sobel).
package conv_pkg;
  localparam int DW_DEF = 16;
  localparam int H_DEF  = 418;
  localparam int CW_DEF = $clog2(H_DEF);
  localparam int GW_DEF = DW_DEF + 3;
  typedef logic [DW_DEF-1:0] pix_t;
endpackage

// File: rtl/conv_window3x3.sv
// 3x3 sliding window fed by three aligned row taps.
// Holds the column counter, the border-masking valid, overflow detection and hs stage 0.
module conv_window3x3 import conv_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int H  = H_DEF,
  localparam int CW = $clog2(H)
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_hs,
  input  logic [DW-1:0]           row1_in,
  input  logic [DW-1:0]           row2_in,
  input  logic [DW-1:0]           row3_in,
  output logic [2:0][2:0][DW-1:0] win,
  output logic                    vld_p0,
  output logic [CW-1:0]           col_p0,
  output logic                    hs_p0,
  output logic                    err_ovf
);
  localparam logic [CW:0] HLIM = (CW+1)'(H);
  localparam logic [CW:0] TWO  = (CW+1)'(2);

  logic [CW:0] col;
  logic [CW:0] cidx;
  logic        acc;

  // cidx is the column of the sample presented this cycle; samples at or
  // beyond H are dropped, so col saturates at H and never wraps.
  always_comb begin
    cidx = in_hs ? '0 : col;
    acc  = in_valid && (cidx < HLIM);
  end

  // stage p0: window shift, centre column, hs delay
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      win     <= '0;
      vld_p0  <= 1'b0;
      col_p0  <= '0;
      hs_p0   <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      hs_p0  <= in_hs;
      vld_p0 <= acc && (cidx >= TWO);
      if (in_hs)
        col <= in_valid ? (CW+1)'(1) : '0;
      else if (acc)
        col <= col + 1'b1;
      if (in_valid && !acc)
        err_ovf <= 1'b1;
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= row1_in;
        win[1][2] <= row2_in;
        win[2][2] <= row3_in;
        col_p0    <= CW'(cidx - 1'b1);
      end
    end
  end
endmodule

// File: rtl/conv_sobel3x3.sv
// Streaming 3x3 Sobel magnitude |Gx|+|Gy| with scale, saturation and edge threshold.
// Fixed 3-cycle latency from window update to output; hs follows the same delay.
module conv_sobel3x3 import conv_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int H      = H_DEF,
  parameter int SHIFT  = 2,
  parameter int THRESH = 64,
  localparam int CW = $clog2(H),
  localparam int GW = DW + 3
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_hs,
  input  logic [DW-1:0] row1_in,
  input  logic [DW-1:0] row2_in,
  input  logic [DW-1:0] row3_in,
  output logic          out_valid,
  output logic          out_hs,
  output logic [DW-1:0] mag_out,
  output logic          edge_out,
  output logic [CW-1:0] out_col,
  output logic          err_ovf
);
  logic [2:0][2:0][DW-1:0] win_p0;
  logic                    vld_p0, hs_p0;
  logic [CW-1:0]           col_p0;

  logic signed [GW-1:0]    gx_p1, gy_p1;
  logic                    vld_p1, hs_p1;
  logic [CW-1:0]           col_p1;

  logic [GW-1:0]           s_p2;
  logic                    vld_p2, hs_p2;
  logic [CW-1:0]           col_p2;

  logic [DW-1:0]           mag_nx;

  // 1-2-1 weighted sum of three pixels, widened so the difference cannot wrap
  function automatic logic signed [GW-1:0] wsum(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic [DW-1:0] c);
    return $signed(GW'(a) + (GW'(b) << 1) + GW'(c));
  endfunction

  function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] v);
    return v[GW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DW-1:0] sat_scale(input logic [GW-1:0] s);
    logic [GW-1:0] sh;
    sh = s >> SHIFT;
    if (|sh[GW-1:DW])
      return '1;
    return sh[DW-1:0];
  endfunction

  conv_window3x3 #(.DW(DW), .H(H)) u_win (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_hs    (in_hs),
    .row1_in  (row1_in),
    .row2_in  (row2_in),
    .row3_in  (row3_in),
    .win      (win_p0),
    .vld_p0   (vld_p0),
    .col_p0   (col_p0),
    .hs_p0    (hs_p0),
    .err_ovf  (err_ovf)
  );

  // stage p1: gradients (Gx right minus left, Gy bottom minus top)
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p1  <= '0;
      gy_p1  <= '0;
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      col_p1 <= '0;
    end else begin
      gx_p1  <= wsum(win_p0[0][2], win_p0[1][2], win_p0[2][2])
              - wsum(win_p0[0][0], win_p0[1][0], win_p0[2][0]);
      gy_p1  <= wsum(win_p0[2][0], win_p0[2][1], win_p0[2][2])
              - wsum(win_p0[0][0], win_p0[0][1], win_p0[0][2]);
      vld_p1 <= vld_p0;
      hs_p1  <= hs_p0;
      col_p1 <= col_p0;
    end
  end

  // stage p2: L1 magnitude
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s_p2   <= '0;
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      col_p2 <= '0;
    end else begin
      s_p2   <= abs_g(gx_p1) + abs_g(gy_p1);
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      col_p2 <= col_p1;
    end
  end

  assign mag_nx = sat_scale(s_p2);

  // output stage: data registers hold between valid samples
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hs    <= 1'b0;
      mag_out   <= '0;
      edge_out  <= 1'b0;
      out_col   <= '0;
    end else begin
      out_valid <= vld_p2;
      out_hs    <= hs_p2;
      if (vld_p2) begin
        mag_out  <= mag_nx;
        edge_out <= (mag_nx >= DW'(THRESH));
        out_col  <= col_p2;
      end
    end
  end
endmodule

// File: tb/tb_conv_sobel3x3.sv
// Scoreboard bench for conv_sobel3x3: an image-array Sobel model predicts each
// output and its cycle; a negedge monitor compares whatever the DUT emits.
module tb_conv_sobel3x3;
  import conv_pkg::*;
  localparam int DW     = 16;
  localparam int H      = 418;
  localparam int SHIFT  = 2;
  localparam int THRESH = 64;
  localparam int CW     = $clog2(H);
  localparam int PMAX   = (1 << DW) - 1;

  typedef struct {
    int mag;
    int edg;
    int col;
    int cyc;
  } exp_t;

  logic          pclk, rst_n, in_valid, in_hs;
  pix_t          row1_in, row2_in, row3_in;
  logic          out_valid, out_hs, edge_out, err_ovf;
  logic [DW-1:0] mag_out;
  logic [CW-1:0] out_col;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mcol = 0;
  int   ovf_cyc = -1;
  int   vcount = 0;
  int   img [3][H];
  exp_t q[$];
  int   hsq[$];

  const int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  const int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  conv_sobel3x3 #(.DW(DW), .H(H), .SHIFT(SHIFT), .THRESH(THRESH)) dut (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_hs    (in_hs),
    .row1_in  (row1_in),
    .row2_in  (row2_in),
    .row3_in  (row3_in),
    .out_valid(out_valid),
    .out_hs   (out_hs),
    .mag_out  (mag_out),
    .edge_out (edge_out),
    .out_col  (out_col),
    .err_ovf  (err_ovf)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t sobel(input int ctr, input int when);
    int gx, gy, s, m;
    exp_t e;
    gx = 0;
    gy = 0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        gx += KX[r][k] * img[r][ctr - 1 + k];
        gy += KY[r][k] * img[r][ctr - 1 + k];
      end
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    m = s >>> SHIFT;
    if (m > PMAX) m = PMAX;
    e.mag = m;
    e.edg = (m >= THRESH) ? 1 : 0;
    e.col = ctr;
    e.cyc = when;
    return e;
  endfunction

  // Inputs applied now are captured at the next edge; outputs appear 3 edges later.
  task automatic model(input bit hs, input bit v, input int a, input int b, input int c);
    if (hs) begin
      mcol = 0;
      hsq.push_back(cyc + 4);
    end
    if (v) begin
      if (mcol >= H) begin
        if (ovf_cyc < 0) ovf_cyc = cyc + 1;
      end else begin
        img[0][mcol] = a;
        img[1][mcol] = b;
        img[2][mcol] = c;
        if (mcol >= 2) q.push_back(sobel(mcol - 1, cyc + 4));
        mcol++;
      end
    end
  endtask

  task automatic drive(input bit hs, input bit v, input int a, input int b, input int c);
    @(posedge pclk);
    #1;
    in_hs    = hs;
    in_valid = v;
    row1_in  = a[DW-1:0];
    row2_in  = b[DW-1:0];
    row3_in  = c[DW-1:0];
    model(hs, v, a, b, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_hs"}, out_hs, 0);
    chk({tag, "_mag_out"}, mag_out, 0);
    chk({tag, "_edge_out"}, edge_out, 0);
    chk({tag, "_out_col"}, out_col, 0);
    chk({tag, "_err_ovf"}, err_ovf, 0);
  endtask

  task automatic do_reset();
    @(posedge pclk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_hs    = 1'b0;
    q.delete();
    hsq.delete();
    mcol    = 0;
    ovf_cyc = -1;
    #1;
    check_zero_outputs("midrst");
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
  endtask

  // monitor
  always @(negedge pclk) begin
    if (rst_n) begin
      if (out_hs || (hsq.size() > 0 && hsq[0] == cyc)) begin
        if (hsq.size() > 0 && hsq[0] == cyc) begin
          void'(hsq.pop_front());
          chk("out_hs", out_hs, 1);
        end else begin
          chk("out_hs_unexpected", out_hs, 0);
        end
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        exp_t m;
        m = q.pop_front();
        chk("out_valid_missing_col", -1, m.col);
      end
      if (out_valid) begin
        vcount++;
        if (q.size() == 0) begin
          chk("out_valid_unexpected", out_valid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("mag_out", mag_out, e.mag);
          chk("edge_out", edge_out, e.edg);
          chk("out_col", out_col, e.col);
        end
      end
      chk("err_ovf", err_ovf, (ovf_cyc >= 0 && cyc >= ovf_cyc) ? 1 : 0);
    end
  end

  initial begin
    int v, gap;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_hs    = 1'b0;
    row1_in  = '0;
    row2_in  = '0;
    row3_in  = '0;
    repeat (3) @(posedge pclk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // flat image, hs on its own cycle before the line
    idle(2);
    vcount = 0;
    drive(1'b1, 1'b0, 0, 0, 0);
    for (int c = 0; c < H; c++) drive(1'b0, 1'b1, 100, 100, 100);
    idle(6);
    chk("flat_pulse_count", vcount, H - 2);

    // vertical step at column 2, hs together with the first sample
    for (int c = 0; c < H; c++) begin
      v = (c >= 2) ? 100 : 0;
      drive(c == 0, 1'b1, v, v, v);
    end
    // bright bottom row only: Gy = 4*max
    for (int c = 0; c < H; c++) drive(c == 0, 1'b1, 0, 0, PMAX);
    // combined horizontal and vertical edge to push past saturation
    for (int c = 0; c < H; c++) begin
      v = (c >= 200) ? PMAX : 0;
      drive(c == 0, 1'b1, v, 0, PMAX);
    end
    idle(4);

    // random lines with gaps, mixing small and full-range pixels
    for (int l = 0; l < 4; l++) begin
      if (l[0]) drive(1'b1, 1'b0, 0, 0, 0);
      for (int c = 0; c < H; c++) begin
        gap = $urandom_range(0, 3);
        if (gap == 0) idle(1);
        if (l[0])
          drive((c == 0) && !l[0], 1'b1, $urandom_range(0, PMAX),
                $urandom_range(0, PMAX), $urandom_range(0, PMAX));
        else
          drive(c == 0, 1'b1, $urandom_range(0, 60), $urandom_range(0, 60),
                $urandom_range(0, 60));
      end
    end
    idle(4);

    // overflow: 420 samples after a single hs
    drive(1'b1, 1'b0, 0, 0, 0);
    for (int c = 0; c < H + 2; c++)
      drive(1'b0, 1'b1, $urandom_range(0, 200), $urandom_range(0, 200),
            $urandom_range(0, 200));
    idle(4);
    chk("err_ovf_sticky", err_ovf, 1);

    // reset in the middle of a random line
    for (int c = 0; c <= 200; c++)
      drive(c == 0, 1'b1, $urandom_range(0, PMAX), $urandom_range(0, PMAX),
            $urandom_range(0, PMAX));
    do_reset();
    idle(6);
    chk("post_reset_quiet", vcount > 0 && out_valid, 0);
    for (int c = 0; c < 40; c++)
      drive(c == 0, 1'b1, $urandom_range(0, 300), $urandom_range(0, 300),
            $urandom_range(0, 300));
    idle(8);

    chk("scoreboard_drained", q.size(), 0);
    chk("hs_drained", hsq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
